// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer
// Reset and lock sequencer for a group of DCM/PLL primitives that share one
// reset line. It pulses the primitives' reset and waits for every LOCKED
// output. If lock does not arrive in time, it retries. Once lock is seen it
// must stay up for a qualification window before the system reset is
// released. The block runs from a free-running reference clock, so it keeps
// working while the DCM outputs are dead.
module dcm_lock_sequencer #(
    parameter int NUM_DCM             = 1,
    parameter int CNT_W               = 16,
    parameter int RST_PULSE_CYCLES    = 4,
    parameter int LOCK_TIMEOUT_CYCLES = 1000,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES         = 3,
    parameter int RETRY_W             = 4,
    parameter int LOSS_W              = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_DCM-1:0] locked_in,
    input  logic               force_relock,
    output logic [NUM_DCM-1:0] dcm_rst,
    output logic               rst_out,
    output logic               all_locked,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOSS_W-1:0]  lock_loss_count
);

    // Sequencer states. RESET_PULSE is also the state held during RST.
    typedef enum logic [2:0] {
        S_RESET_PULSE = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_STABLE      = 3'd2,
        S_RUN         = 3'd3,
        S_FAILED      = 3'd4
    } state_t;

    // Terminal counts. The counter starts at zero on state entry, so an
    // N-cycle window ends when the counter reads N-1.
    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [RETRY_W-1:0] retry_next;
    logic [LOSS_W-1:0]  loss_next;

    logic [NUM_DCM-1:0] sync_meta;
    logic [NUM_DCM-1:0] sync_out;
    logic               locked_s;

    // Two-flop synchroniser per LOCKED bit. The DCM outputs are asynchronous
    // to CLK. Both stages clear on RST so a restart never sees stale lock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= locked_in;
            sync_out  <= sync_meta;
        end
    end

    // Lock counts only when every channel reports lock.
    assign locked_s = &sync_out;

    // Next-state logic, including the counter and the retry and loss
    // bookkeeping. force_relock overrides every state transition.
    always_comb begin
        next_state = state;
        retry_next = retry_count;
        loss_next  = lock_loss_count;
        cnt_next   = cnt;

        if (force_relock) begin
            next_state = S_RESET_PULSE;
            retry_next = '0;
        end else begin
            case (state)
                S_RESET_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        next_state = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_LIMIT) begin
                            next_state = S_FAILED;
                        end else begin
                            retry_next = retry_count + RETRY_W'(1);
                            next_state = S_RESET_PULSE;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        next_state = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        next_state = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        if (lock_loss_count != '1) begin
                            loss_next = lock_loss_count + LOSS_W'(1);
                        end
                        retry_next = '0;
                        next_state = S_RESET_PULSE;
                    end
                end
                S_FAILED: begin
                    next_state = S_FAILED;
                end
                default: begin
                    next_state = S_RESET_PULSE;
                end
            endcase
        end

        // The counter restarts on every state entry. A force_relock also
        // restarts it when the state is already RESET_PULSE, so the pulse
        // runs its full length again. The counter advances only in timed
        // states, so it stays put while in RUN or FAILED.
        if (force_relock || (next_state != state)) begin
            cnt_next = '0;
        end else if ((state == S_RESET_PULSE) || (state == S_WAIT_LOCK) ||
                     (state == S_STABLE)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // State register, shared counter, and retry and loss counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= S_RESET_PULSE;
            cnt             <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else begin
            state           <= next_state;
            cnt             <= cnt_next;
            retry_count     <= retry_next;
            lock_loss_count <= loss_next;
        end
    end

    // Registered Moore outputs. They decode the state being entered, so each
    // output register always matches the state register in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dcm_rst    <= '1;
            rst_out    <= 1'b1;
            all_locked <= 1'b0;
            fail       <= 1'b0;
        end else begin
            dcm_rst    <= {NUM_DCM{next_state == S_RESET_PULSE}};
            rst_out    <= (next_state != S_RUN);
            all_locked <= (next_state == S_RUN);
            fail       <= (next_state == S_FAILED);
        end
    end

endmodule
